// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every N_IN-bit vector into a Skolem block and checks it against an oracle.
// Optional build macro SKOLEM_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module skolem_sweep_ctrl #(
    parameter int N_IN = 8,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            fn_i,
    input  logic            ref_i,
    output logic [N_IN-1:0] vec_o,
    output logic            vec_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   mis_cnt_o,
    output logic [N_IN-1:0] fail_vec_o,
    output logic            fail_vld_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // With no settle time a fresh vector is sampled in the very cycle it appears.
    localparam state_t        FIRST       = (LAT == 0) ? SAMPLE : RUN;
    localparam logic [3:0]    SETTLE_LAST = 4'((LAT == 0) ? 0 : LAT - 1);
    localparam logic [N_IN:0] VEC_LAST    = {1'b0, {N_IN{1'b1}}};

    state_t          state, state_d;
    logic [N_IN:0]   vec, vec_d;
    logic [3:0]      settle, settle_d;
    logic [N_IN:0]   mis_cnt, mis_cnt_d;
    logic [N_IN-1:0] fail_vec, fail_vec_d;
    logic            fail_vld, fail_vld_d;
    logic            pass, pass_d;
    logic            mismatch;
    logic            stop;

    // Gating with the state keeps X on fn_i/ref_i out of the counters between samples.
    assign mismatch = (state == SAMPLE) && (fn_i != ref_i);

`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            settle   <= '0;
            mis_cnt  <= '0;
            fail_vec <= '0;
            fail_vld <= 1'b0;
            pass     <= 1'b0;
        end else begin
            vec      <= vec_d;
            settle   <= settle_d;
            mis_cnt  <= mis_cnt_d;
            fail_vec <= fail_vec_d;
            fail_vld <= fail_vld_d;
            pass     <= pass_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_d    = state;
        vec_d      = vec;
        settle_d   = settle;
        mis_cnt_d  = mis_cnt;
        fail_vec_d = fail_vec;
        fail_vld_d = fail_vld;
        pass_d     = pass;

        if (abort) begin
            // Partial counts and the first failing vector are kept for debug.
            state_d  = IDLE;
            settle_d = '0;
            pass_d   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_d    = FIRST;
                        vec_d      = '0;
                        settle_d   = '0;
                        mis_cnt_d  = '0;
                        fail_vec_d = '0;
                        fail_vld_d = 1'b0;
                        pass_d     = 1'b0;
                    end
                end
                RUN: begin
                    if (settle == SETTLE_LAST) begin
                        state_d  = SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        mis_cnt_d = mis_cnt + 1'b1;
                        if (!fail_vld) begin
                            fail_vec_d = vec[N_IN-1:0];
                            fail_vld_d = 1'b1;
                        end
                    end
                    if (vec == VEC_LAST || stop) begin
                        state_d = DONE;
                        pass_d  = (mis_cnt_d == '0);
                    end else begin
                        state_d = FIRST;
                        vec_d   = vec + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign vec_o       = vec[N_IN-1:0];
    assign vec_valid_o = (state == RUN) || (state == SAMPLE);
    assign busy_o      = (state == RUN) || (state == SAMPLE);
    assign done_o      = (state == DONE);
    assign pass_o      = pass;
    assign mis_cnt_o   = mis_cnt;
    assign fail_vec_o  = fail_vec;
    assign fail_vld_o  = fail_vld;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: random fn/ref patterns against a per-vector reference model,
// plus abort, reset and settle-latency (LAT=0/3) duration checks.
module tb_skolem_sweep_ctrl;

    localparam int N_IN = 8;
    localparam int LAT  = 1;
    localparam int NV   = 1 << N_IN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            fn = 1'b0;
    logic            rf = 1'b0;
    logic [N_IN-1:0] vec;
    logic            vec_valid, busy, done, pass, fail_vld;
    logic [N_IN:0]   mis_cnt;
    logic [N_IN-1:0] fail_vec;

    logic            start0 = 1'b0;
    logic            start3 = 1'b0;
    logic [N_IN-1:0] vec0, vec3, fvec0, fvec3;
    logic            vv0, vv3, busy0, busy3, done0, done3, pass0, pass3, fv0, fv3;
    logic [N_IN:0]   mis0, mis3;

    skolem_sweep_ctrl #(.N_IN(N_IN), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fn_i(fn), .ref_i(rf),
        .vec_o(vec), .vec_valid_o(vec_valid), .busy_o(busy), .done_o(done), .pass_o(pass),
        .mis_cnt_o(mis_cnt), .fail_vec_o(fail_vec), .fail_vld_o(fail_vld)
    );

    skolem_sweep_ctrl #(.N_IN(N_IN), .LAT(0)) dut_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .fn_i(1'b0), .ref_i(1'b0),
        .vec_o(vec0), .vec_valid_o(vv0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .mis_cnt_o(mis0), .fail_vec_o(fvec0), .fail_vld_o(fv0)
    );

    skolem_sweep_ctrl #(.N_IN(N_IN), .LAT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .fn_i(1'b0), .ref_i(1'b0),
        .vec_o(vec3), .vec_valid_o(vv3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .mis_cnt_o(mis3), .fail_vec_o(fvec3), .fail_vld_o(fv3)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference stimulus: fn value per vector and whether ref disagrees with it.
    bit fnv [NV];
    bit msk [NV];

    task automatic make_pattern(input int mode);
        for (int v = 0; v < NV; v++) begin
            fnv[v] = 1'($urandom_range(0, 1));
            case (mode)
                0:       msk[v] = 1'b0;
                1:       msk[v] = (v == 8'h5A);
                2:       msk[v] = v[0];
                3:       msk[v] = ($urandom_range(0, 31) == 0);
                4:       msk[v] = 1'($urandom_range(0, 1));
                5:       msk[v] = (v == NV - 1);
                default: msk[v] = 1'b0;
            endcase
        end
    endtask

    function automatic logic [29:0] all_out();
        return {vec, vec_valid, busy, done, pass, mis_cnt, fail_vec, fail_vld};
    endfunction

    // Drive fn/ref for cycle c of a sweep: real values only in the sample cycle of a vector.
    task automatic drive_data(input int c);
        int k;
        k = (c - 1) / (LAT + 1);
        if (c % (LAT + 1) == 0 && k < NV) begin
            fn = fnv[k];
            rf = fnv[k] ^ msk[k];
        end else begin
            fn = 1'bx;
            rf = 1'bx;
        end
    endtask

    task automatic run_sweep(input string name, input bit hold_start, input int extra_start_at);
        int mis, first, last_v, done_cyc, seq_bad, k;
        mis = 0; first = -1; last_v = NV - 1; seq_bad = 0;
        for (int v = 0; v < NV; v++) begin
            if (msk[v]) begin
                mis++;
                if (first < 0) first = v;
            end
        end
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        if (first >= 0) begin
            last_v = first;
            mis    = 1;
        end
`endif
        done_cyc = (last_v + 1) * (LAT + 1) + 1;
        start = 1'b1; abort = 1'b0; fn = 1'bx; rf = 1'bx;
        @(posedge clk); #1;
        for (int c = 1; c < done_cyc; c++) begin
            k = (c - 1) / (LAT + 1);
            if (busy !== 1'b1 || vec_valid !== 1'b1 || done !== 1'b0 || vec !== 8'(k)) seq_bad++;
            start = hold_start || (c == extra_start_at);
            drive_data(c);
            @(posedge clk); #1;
        end
        check({name, "/seq_errs"}, seq_bad, 0);
        check({name, "/done"}, done, 1);
        check({name, "/busy_at_done"}, {busy, vec_valid}, 0);
        check({name, "/pass"}, pass, (mis == 0));
        check({name, "/mis_cnt"}, mis_cnt, mis);
        check({name, "/fail_vld"}, fail_vld, (first >= 0));
        if (first >= 0) check({name, "/fail_vec"}, fail_vec, first);
        start = hold_start; fn = 1'bx; rf = 1'bx;
        @(posedge clk); #1;
        check({name, "/after_done"}, {done, busy, pass, mis_cnt}, {1'b0, 1'b0, (mis == 0), 9'(mis)});
        start = 1'b0;
        @(posedge clk); #1;
        check({name, "/stays_idle"}, {busy, done}, 0);
    endtask

    task automatic run_abort(input int a);
        int mis, first, seq_bad, k, dn;
        mis = 0; first = -1; seq_bad = 0; dn = 0;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        for (int v = 0; v < NV; v++) msk[v] = 1'b0;
`endif
        // Samples strictly before the abort cycle count; the one in the abort cycle is dropped.
        for (int v = 0; v < NV; v++) begin
            if ((v + 1) * (LAT + 1) < a && msk[v]) begin
                mis++;
                if (first < 0) first = v;
            end
        end
        start = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= a; c++) begin
            k = (c - 1) / (LAT + 1);
            if (busy !== 1'b1 || done !== 1'b0 || vec !== 8'(k)) seq_bad++;
            start = 1'b0;
            abort = (c == a);
            drive_data(c);
            @(posedge clk); #1;
        end
        abort = 1'b0; fn = 1'bx; rf = 1'bx;
        check("abort/seq_errs", seq_bad, 0);
        check("abort/idle_next", {busy, vec_valid, done, pass}, 0);
        check("abort/mis_partial", mis_cnt, mis);
        check("abort/fail_vld_partial", fail_vld, (first >= 0));
        if (first >= 0) check("abort/fail_vec_partial", fail_vec, first);
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dn++;
            @(posedge clk); #1;
        end
        check("abort/no_done", dn, 0);
    endtask

    task automatic run_reset_mid(input int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= cyc; c++) begin
            start = 1'b0;
            drive_data(c);
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/outputs", all_out(), 0);
        @(posedge clk); #1;
        check("rst_mid/held", all_out(), 0);
        rst_n = 1'b1; fn = 1'b0; rf = 1'b0;
        @(posedge clk); #1;
        check("rst_mid/idle_after", {busy, done}, 0);
    endtask

    task automatic run_durations();
        int d0, d3, n0, n3;
        d0 = -1; d3 = -1; n0 = 0; n3 = 0;
        start0 = 1'b1; start3 = 1'b1;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start3 = 1'b0;
            if (done0 === 1'b1) begin
                n0++;
                if (d0 < 0) begin
                    d0 = c;
                    check("lat0/pass", {pass0, mis0, fv0}, {1'b1, 9'd0, 1'b0});
                end
            end
            if (done3 === 1'b1) begin
                n3++;
                if (d3 < 0) begin
                    d3 = c;
                    check("lat3/pass", {pass3, mis3, fv3}, {1'b1, 9'd0, 1'b0});
                end
            end
        end
        check("lat0/duration", d0, 257);
        check("lat3/duration", d3, 1025);
        check("lat_done_pulses", {n0[7:0], n3[7:0]}, {8'd1, 8'd1});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset/outputs", all_out(), 0);
        check("reset/aux", {busy0, done0, busy3, done3, vec3, mis3}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset/idle", {busy, done}, 0);

        make_pattern(0); run_sweep("t1_clean", 1'b0, -1);
        make_pattern(1); run_sweep("t2_5a", 1'b0, -1);
        make_pattern(2); run_sweep("t3_lsb", 1'b0, -1);
        make_pattern(3); run_abort(100);
        make_pattern(4); run_sweep("t4_restart", 1'b0, -1);
        make_pattern(3); run_sweep("t5_hold", 1'b1, 200);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("start_abort_idle", {busy, vec_valid, pass}, 0);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            make_pattern(int'($urandom_range(0, 5)));
            run_sweep("rand", 1'($urandom_range(0, 1)), int'($urandom_range(1, 500)));
        end

        make_pattern(4); run_reset_mid(150);
        make_pattern(5); run_sweep("post_rst", 1'b0, 37);

        run_durations();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
